// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared types and constants for the ALU-side datapath units.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Divider controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // Quotient reported for a zero divisor at the default width
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division step: shift in a dividend bit, trial-subtract.
// Revision: 1.0 - initial release
// ============================================================================
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_shifted = {rem, q_msb};
        w_diff    = w_shifted - {1'b0, divisor};
        // A clear MSB means the subtraction did not borrow
        q_bit     = ~w_diff[WIDTH];
        rem_next  = q_bit ? w_diff : w_shifted;
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : Multi-cycle unsigned restoring divider with valid/ready channels.
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int              CW              = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   c_last_step     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_zero_quotient = {WIDTH{1'b1}};

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_div_zero;

    logic [WIDTH:0]   w_rem_next;
    logic             w_q_bit;
    logic             w_accept;
    logic             w_unused_rem_msb;

    // A restored remainder is always below the divisor, so its top bit never reaches the output
    assign w_unused_rem_msb = r_rem[WIDTH];

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (r_rem[WIDTH-1:0]),
        .q_msb    (r_q[WIDTH-1]),
        .divisor  (r_divisor),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_next = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_count == c_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_count    <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_divisor <= divisor;
                r_count   <= '0;
                if (divisor == '0) begin
                    r_q        <= c_zero_quotient;
                    r_rem      <= {1'b0, dividend};
                    r_div_zero <= 1'b1;
                end else begin
                    r_q        <= dividend;
                    r_rem      <= '0;
                    r_div_zero <= 1'b0;
                end
            end else if (r_state == BUSY) begin
                r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                r_rem <= w_rem_next;
                if (r_count != c_last_step) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign quotient  = r_q;
    assign remainder = r_rem[WIDTH-1:0];
    assign div_zero  = r_div_zero;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Self-checking bench for seq_divider against a plain-arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Issues one request, waits for the result and completes the response handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit early_ready,
                          output logic [7:0] q, output logic [7:0] r, output logic dz,
                          output int lat, output bit ok);
        int guard;
        ok  = 1'b1;
        lat = 0;
        q   = 'x;
        r   = 'x;
        dz  = 1'bx;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = early_ready;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%0d r=%0d dz=%b, want rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic dz; int lat; bit ok;
        run_op(8'd200, 8'd7, 1'b1, q, r, dz, lat, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: no handshake/result within bound"); return; end
        n_cmp++;
        if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d, want 8", lat); end
        n_cmp++;
        if ({q, r, dz} !== {8'd28, 8'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want q=28 r=4 dz=0", q, r, dz);
        end
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_ready_after: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic dz; int lat; bit ok;
        run_op(8'd17, 8'd0, 1'b0, q, r, dz, lat, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL divzero_timeout: no handshake/result within bound"); return; end
        n_cmp++;
        if (lat !== 0) begin n_fail++; $display("FAIL divzero_latency: got %0d extra edges, want 0", lat); end
        n_cmp++;
        if ({q, r, dz} !== {8'hFF, 8'd17, 1'b1}) begin
            n_fail++;
            $display("FAIL divzero_result: got q=%0h r=%0d dz=%b, want q=ff r=17 dz=1", q, r, dz);
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        dividend = 8'd100; divisor = 8'd10; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        n_cmp++;
        if (!out_valid) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose"); return; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd10, 8'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%0d r=%0d dz=%b, want vld=1 rdy=0 q=10 r=0 dz=0",
                         i, out_valid, in_ready, quotient, remainder, div_zero);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rq [2];
        logic [7:0] rr [2];
        int n_acc = 0;
        int n_res = 0;
        bit acc_now, res_now;
        dividend = 8'd255; divisor = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n_res < 2; cyc++) begin
            acc_now = in_valid && in_ready;
            res_now = out_valid && out_ready;
            if (acc_now && n_acc == 1) begin
                n_cmp++;
                if (n_res !== 1) begin
                    n_fail++;
                    $display("FAIL b2b_order: second accept after %0d responses, want 1", n_res);
                end
            end
            if (res_now) begin
                rq[n_res] = quotient;
                rr[n_res] = remainder;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                n_acc++;
                if (n_acc == 1) begin dividend = 8'd5; divisor = 8'd9; end
                else in_valid = 1'b0;
            end
            if (res_now) n_res++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (n_res !== 2 || n_acc !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d accepts %0d responses, want 2 and 2", n_acc, n_res);
            return;
        end
        n_cmp++;
        if ({rq[0], rr[0], rq[1], rr[1]} !== {8'd255, 8'd0, 8'd0, 8'd5}) begin
            n_fail++;
            $display("FAIL b2b_result: got (%0d,%0d) (%0d,%0d), want (255,0) (0,5)", rq[0], rr[0], rq[1], rr[1]);
        end
    endtask

    task automatic test_reset_busy();
        logic [7:0] q, r; logic dz; int lat; bit ok;
        dividend = 8'd200; divisor = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Three further steps leave the step counter at 3
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_reset_state: got rdy=%b vld=%b q=%0d r=%0d dz=%b, want rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
        run_op(8'd9, 8'd2, 1'b1, q, r, dz, lat, ok);
        n_cmp++;
        if (!ok || {q, r, dz} !== {8'd4, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_reset_followup: ok=%b got q=%0d r=%0d dz=%b, want q=4 r=1 dz=0", ok, q, r, dz);
        end
    endtask

    function automatic logic [7:0] pick_operand();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return 8'd0;
        if (sel == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_random();
        logic [7:0] a, b, q, r, eq, er; logic dz, edz; int lat, elat; bit ok;
        for (int i = 0; i < 1000; i++) begin
            a = pick_operand();
            b = pick_operand();
            if (b == 0) begin
                eq = 8'hFF; er = a; edz = 1'b1; elat = 0;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0; elat = WIDTH;
            end
            run_op(a, b, 1'($urandom_range(0, 1)), q, r, dz, lat, ok);
            n_cmp++;
            if (!ok || lat !== elat || {q, r, dz} !== {eq, er, edz}) begin
                n_fail++;
                $display("FAIL rand[%0d] %0d/%0d: ok=%b got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=%b lat=%0d",
                         i, a, b, ok, q, r, dz, lat, eq, er, edz, elat);
            end
            if (b != 0) begin
                n_cmp++;
                if (!(r < b)) begin
                    n_fail++;
                    $display("FAIL rand_rem_bound[%0d]: got r=%0d, want r < %0d", i, r, b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
